// File: rtl/div_share_ctrl.sv
// Two-port round-robin front end for a shared iterative signed restoring divider.
// One restore step per clock; the result is held on a shared bus until the owner takes it.
module div_share_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_dividend,
  input  logic [2*WIDTH-1:0]   req_divisor,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [WIDTH-1:0]     resp_quo,
  output logic [WIDTH-1:0]     resp_rem,
  output logic                 resp_dz,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic             rr_last_reg;
  logic             owner_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] p_reg;
  logic [CW-1:0]    count_reg;
  logic             dvd_neg_reg;
  logic             dvs_neg_reg;
  logic             dz_reg;
  logic [WIDTH-1:0] raw_dvd_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             resp_dz_reg;

  logic [WIDTH-1:0] op_dvd [2];
  logic [WIDTH-1:0] op_dvs [2];
  logic             grant_any;
  logic             winner;
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dvs;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] p_shift;
  logic [WIDTH:0]   diff;
  logic             diff_neg;

  // Per-requester operand slices and one-hot handshake strobes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign op_dvd[gi]     = req_dividend[gi*WIDTH +: WIDTH];
    assign op_dvs[gi]     = req_divisor[gi*WIDTH +: WIDTH];
    assign req_ready[gi]  = (state_reg == IDLE) && grant_any && (winner == 1'(gi));
    assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
  end

  // On a tie the requester that did not win last time is preferred.
  always_comb begin
    grant_any = |req_valid;
    winner    = 1'b0;
    case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~rr_last_reg;
      default: winner = 1'b0;
    endcase
  end

  assign sel_dvd = winner ? op_dvd[1] : op_dvd[0];
  assign sel_dvs = winner ? op_dvs[1] : op_dvs[0];
  assign dvd_mag = sel_dvd[WIDTH-1] ? (WIDTH'(0) - sel_dvd) : sel_dvd;
  assign dvs_mag = sel_dvs[WIDTH-1] ? (WIDTH'(0) - sel_dvs) : sel_dvs;

  assign p_shift  = {p_reg[WIDTH-2:0], a_reg[WIDTH-1]};
  assign diff     = {1'b0, p_shift} - {1'b0, b_reg};
  assign diff_neg = diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rr_last_reg <= 1'b1;
      owner_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      p_reg       <= '0;
      count_reg   <= '0;
      dvd_neg_reg <= 1'b0;
      dvs_neg_reg <= 1'b0;
      dz_reg      <= 1'b0;
      raw_dvd_reg <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      resp_dz_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            owner_reg   <= winner;
            rr_last_reg <= winner;
            a_reg       <= dvd_mag;
            b_reg       <= dvs_mag;
            dvd_neg_reg <= sel_dvd[WIDTH-1];
            dvs_neg_reg <= sel_dvs[WIDTH-1];
            dz_reg      <= (sel_dvs == '0);
            raw_dvd_reg <= sel_dvd;
            p_reg       <= '0;
            count_reg   <= '0;
            state_reg   <= CALC;
          end
        end
        CALC: begin
          p_reg     <= diff_neg ? p_shift : diff[WIDTH-1:0];
          a_reg     <= {a_reg[WIDTH-2:0], ~diff_neg};
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_STEP) state_reg <= SIGN;
        end
        SIGN: begin
          // Truncating division: quotient sign from both operands, remainder follows the dividend.
          if (dz_reg) begin
            quo_reg     <= '1;
            rem_reg     <= raw_dvd_reg;
            resp_dz_reg <= 1'b1;
          end else begin
            quo_reg     <= (dvd_neg_reg ^ dvs_neg_reg) ? (WIDTH'(0) - a_reg) : a_reg;
            rem_reg     <= dvd_neg_reg ? (WIDTH'(0) - p_reg) : p_reg;
            resp_dz_reg <= 1'b0;
          end
          state_reg <= RESP;
        end
        RESP: begin
          if (resp_ready[owner_reg]) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_quo = quo_reg;
  assign resp_rem = rem_reg;
  assign resp_dz  = resp_dz_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: latency, sign handling, divide-by-zero,
// arbitration, response backpressure and mid-operation reset.
module tb_div_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req_dividend = '0;
  logic [15:0] req_divisor = '0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b11;
  logic [7:0]  resp_quo;
  logic [7:0]  resp_rem;
  logic        resp_dz;
  logic        busy;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quo(resp_quo), .resp_rem(resp_rem), .resp_dz(resp_dz),
    .busy(busy)
  );

  // Issues one operation on requester idx with resp_ready high and returns what came back.
  task automatic run_op(input int idx, input logic [7:0] dvd, input logic [7:0] dvs,
                        output logic [7:0] q, output logic [7:0] r, output logic dz,
                        output int lat, output logic rdy_after);
    int waited;
    q = '0; r = '0; dz = 1'b0; lat = -1; rdy_after = 1'b1;
    @(negedge clk);
    req_dividend[idx*8 +: 8] = dvd;
    req_divisor[idx*8 +: 8]  = dvs;
    req_valid[idx] = 1'b1;
    waited = 0;
    #1;
    while (!req_ready[idx] && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready[idx]) begin
      req_valid[idx] = 1'b0;
      return;
    end
    @(negedge clk);
    rdy_after = req_ready[idx];
    req_valid[idx] = 1'b0;
    lat = 1;
    while (!resp_valid[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = resp_quo; r = resp_rem; dz = resp_dz;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({req_ready, resp_valid, resp_quo, resp_rem, resp_dz, busy} !== 22'h0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b q=%h r=%h dz=%b busy=%b, want all zero",
               req_ready, resp_valid, resp_quo, resp_rem, resp_dz, busy);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy);
    else pass_cnt++;
    $display("reset: released");
  endtask

  task automatic test_basic;
    logic [7:0] q, r; logic dz, ra; int lat;
    run_op(0, 8'd100, 8'd7, q, r, dz, lat, ra);
    $display("basic: 100/7 -> q=%h r=%h dz=%b lat=%0d", q, r, dz, lat);
    chk_cnt++;
    if (ra !== 1'b0) $display("FAIL ready_pulse: req_ready after accept=%b want 0", ra);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 10) $display("FAIL latency: got %0d want 10", lat);
    else pass_cnt++;
    chk_cnt++;
    if ({q, r, dz} !== {8'h0E, 8'h02, 1'b0})
      $display("FAIL basic_result: got q=%h r=%h dz=%b want q=0e r=02 dz=0", q, r, dz);
    else pass_cnt++;
  endtask

  task automatic test_signs;
    logic [7:0] q, r; logic dz, ra; int lat;
    logic [7:0] va [5]; logic [7:0] vb [5]; logic [7:0] eq [5]; logic [7:0] er [5];
    va[0] = 8'h9C; vb[0] = 8'h07; eq[0] = 8'hF2; er[0] = 8'hFE;  // -100 / 7
    va[1] = 8'h64; vb[1] = 8'hF9; eq[1] = 8'hF2; er[1] = 8'h02;  // 100 / -7
    va[2] = 8'h9C; vb[2] = 8'hF9; eq[2] = 8'h0E; er[2] = 8'hFE;  // -100 / -7
    va[3] = 8'h80; vb[3] = 8'hFF; eq[3] = 8'h80; er[3] = 8'h00;  // -128 / -1
    va[4] = 8'h80; vb[4] = 8'h01; eq[4] = 8'h80; er[4] = 8'h00;  // -128 / 1
    for (int i = 0; i < 5; i++) begin
      run_op(i % 2, va[i], vb[i], q, r, dz, lat, ra);
      $display("signs: %h/%h -> q=%h r=%h dz=%b", va[i], vb[i], q, r, dz);
      chk_cnt++;
      if ({q, r, dz} !== {eq[i], er[i], 1'b0})
        $display("FAIL sign_%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=0", i, q, r, dz, eq[i], er[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_divzero;
    logic [7:0] q, r; logic dz, ra; int lat;
    logic [7:0] va [2];
    va[0] = 8'h25; va[1] = 8'hA0;
    for (int i = 0; i < 2; i++) begin
      run_op(i, va[i], 8'h00, q, r, dz, lat, ra);
      $display("divzero: %h/00 -> q=%h r=%h dz=%b", va[i], q, r, dz);
      chk_cnt++;
      if ({q, r, dz} !== {8'hFF, va[i], 1'b1})
        $display("FAIL divzero_%0d: got q=%h r=%h dz=%b want q=ff r=%h dz=1", i, q, r, dz, va[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_contention;
    int g [4]; int ng; int cyc;
    logic [15:0] res0, res1;
    ng = 0; res0 = '1; res1 = '1;
    for (int i = 0; i < 4; i++) g[i] = -1;
    @(negedge clk);
    rst_n = 1'b0;
    req_dividend = {8'd60, 8'd50};
    req_divisor  = {8'd7, 8'd5};
    req_valid = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (ng < 4 && cyc < 200) begin
      #1;
      if (req_ready[0] && ng < 4) begin g[ng] = 0; ng++; end
      else if (req_ready[1] && ng < 4) begin g[ng] = 1; ng++; end
      if (resp_valid[0] && res0 == 16'hFFFF) res0 = {resp_quo, resp_rem};
      if (resp_valid[1] && res1 == 16'hFFFF) res1 = {resp_quo, resp_rem};
      @(negedge clk);
      cyc++;
    end
    req_valid = 2'b00;
    $display("contention: grants %0d %0d %0d %0d res0=%h res1=%h", g[0], g[1], g[2], g[3], res0, res1);
    chk_cnt++;
    if (ng !== 4) $display("FAIL contention_timeout: got %0d grants want 4", ng);
    else pass_cnt++;
    chk_cnt++;
    if (g[0] !== 0 || g[1] !== 1 || g[2] !== 0 || g[3] !== 1)
      $display("FAIL grant_order: got %0d%0d%0d%0d want 0101", g[0], g[1], g[2], g[3]);
    else pass_cnt++;
    chk_cnt++;
    if (res0 !== {8'd10, 8'd0}) $display("FAIL contention_req0: got %h want 0a00", res0);
    else pass_cnt++;
    chk_cnt++;
    if (res1 !== {8'd8, 8'd4}) $display("FAIL contention_req1: got %h want 0804", res1);
    else pass_cnt++;
    cyc = 0;
    while (busy && cyc < 40) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_backpressure;
    int cyc; logic stable; logic [16:0] held; logic granted1;
    @(negedge clk);
    resp_ready = 2'b10;
    req_dividend[7:0] = 8'd77; req_divisor[7:0] = 8'd3;
    req_valid[0] = 1'b1;
    cyc = 0;
    #1;
    while (!req_ready[0] && cyc < 40) begin @(negedge clk); #1; cyc++; end
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_dividend[15:8] = 8'd20; req_divisor[15:8] = 8'd3;
    req_valid[1] = 1'b1;
    cyc = 0;
    while (!resp_valid[0] && cyc < 40) begin @(negedge clk); cyc++; end
    held = {resp_quo, resp_rem, resp_dz};
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid !== 2'b01 || {resp_quo, resp_rem, resp_dz} !== held || req_ready !== 2'b00)
        stable = 1'b0;
    end
    $display("backpressure: held q=%h r=%h dz=%b stable=%b", held[16:9], held[8:1], held[0], stable);
    chk_cnt++;
    if (held !== {8'd25, 8'd2, 1'b0}) $display("FAIL stall_result: got %h want %h", held, {8'd25, 8'd2, 1'b0});
    else pass_cnt++;
    chk_cnt++;
    if (stable !== 1'b1) $display("FAIL stall_stable: stable=%b want 1", stable);
    else pass_cnt++;
    resp_ready = 2'b11;
    @(negedge clk);
    #1;
    granted1 = req_ready[1];
    chk_cnt++;
    if (req_ready !== 2'b10) $display("FAIL stall_release_grant: req_ready=%b want 10", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid[1] = 1'b0;
    cyc = 0;
    while (!resp_valid[1] && cyc < 40 && granted1) begin @(negedge clk); cyc++; end
    chk_cnt++;
    if ({resp_valid[1], resp_quo, resp_rem} !== {1'b1, 8'd6, 8'd2})
      $display("FAIL stall_req1: got vld=%b q=%h r=%h want vld=1 q=06 r=02", resp_valid[1], resp_quo, resp_rem);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_midcalc;
    logic [7:0] q, r; logic dz, ra; int lat; int cyc; logic stale;
    @(negedge clk);
    req_dividend[7:0] = 8'd100; req_divisor[7:0] = 8'd7;
    req_valid[0] = 1'b1;
    cyc = 0;
    #1;
    while (!req_ready[0] && cyc < 40) begin @(negedge clk); #1; cyc++; end
    @(posedge clk);
    req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({req_ready, resp_valid, resp_quo, resp_rem, resp_dz, busy} !== 22'h0)
      $display("FAIL midcalc_reset: got rdy=%b vld=%b q=%h r=%h dz=%b busy=%b, want all zero",
               req_ready, resp_valid, resp_quo, resp_rem, resp_dz, busy);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (resp_valid !== 2'b00 || busy !== 1'b0) stale = 1'b1;
    end
    chk_cnt++;
    if (stale !== 1'b0) $display("FAIL stale_response: activity after reset=%b want 0", stale);
    else pass_cnt++;
    run_op(0, 8'd9, 8'd2, q, r, dz, lat, ra);
    $display("reset_midcalc: 9/2 -> q=%h r=%h dz=%b lat=%0d", q, r, dz, lat);
    chk_cnt++;
    if ({q, r, dz} !== {8'd4, 8'd1, 1'b0})
      $display("FAIL post_reset_op: got q=%h r=%h dz=%b want q=04 r=01 dz=0", q, r, dz);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_divzero;
    test_contention;
    test_backpressure;
    test_reset_midcalc;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Sequencing controller and two-port arbiter for a shared iterative signed restoring divider. Two requesters submit 8-bit (WIDTH-bit) two's-complement dividend/divisor pairs over valid/ready handshakes. A round-robin arbiter grants one request at a time. The block runs one restore step per clock and returns quotient/remainder to the granted requester over a held valid/ready response. It sits between CPU-side issue logic and the divide datapath, replacing per-requester combinational dividers.

## Interface
- WIDTH, 8, operand/result width; iteration count equals WIDTH
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  bit i: requester i has an operand pair
- req_ready  out  2  bit i: requester i's pair accepted this cycle
- req_dividend  in  2*WIDTH  requester i at [i*WIDTH +: WIDTH], two's complement
- req_divisor  in  2*WIDTH  requester i at [i*WIDTH +: WIDTH], two's complement
- resp_valid  out  2  bit i: result for requester i on the shared result bus
- resp_ready  in  2  bit i: requester i takes the result
- resp_quo  out  WIDTH  quotient
- resp_rem  out  WIDTH  remainder
- resp_dz  out  1  divide-by-zero flag
- busy  out  1  high in every state except IDLE

## Operation
- FSM: IDLE -> CALC -> SIGN -> RESP -> IDLE.
- IDLE:
  - Arbiter picks one valid requester.
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than rr_last wins.
  - req_ready is driven combinationally, one-hot to the winner, and only in IDLE.
  - On the handshake edge the block latches |dividend|, |divisor|, both sign bits, the raw dividend, a divisor==0 flag, and owner=winner.
  - On the same edge: rr_last<=winner, partial remainder P<=0, count<=0, next state CALC.
- Magnitudes: |x| = (x[WIDTH-1] ? 0-x : x), computed modulo 2^WIDTH. The value -2^(WIDTH-1) maps to the unsigned magnitude 2^(WIDTH-1).
- CALC: one restoring step per cycle, WIDTH cycles total. Each step:
  - P = {P[WIDTH-2:0], A[WIDTH-1]}; A shifts left by one.
  - D = P - B, computed at WIDTH+1 bits.
  - If D is negative: A[0]=0 and P is kept (restore). Otherwise A[0]=1 and P=D.
  - count increments. When count reaches WIDTH-1, next state is SIGN.
- SIGN: one cycle; loads the output registers.
  - If the divisor was 0: quo = all-ones, rem = raw dividend, dz = 1.
  - Otherwise: quo = A negated if the sign bits differ; rem = P negated if the dividend was negative; dz = 0. This gives truncation toward zero; the remainder takes the dividend's sign.
  - Overflow wraps: -2^(WIDTH-1) / -1 gives quo = 2^(WIDTH-1) bit pattern, rem = 0, no flag.
- RESP:
  - resp_valid[owner]=1; the other bit stays 0.
  - quo, rem and dz are held stable until resp_ready[owner]=1 at a clock edge, then next state is IDLE.
  - resp_ready of the non-owner is ignored.
- Requesters hold req_dividend/req_divisor stable while req_valid is high. A dropped req_valid before ready is legal: that requester simply is not granted.
- A requester losing arbitration stays pending and is granted at the next IDLE, since it is now preferred.

## Timing
- Reset (async assert, any state): state=IDLE, rr_last=1 (requester 0 wins first tie), req_ready=0, resp_valid=0, resp_quo=0, resp_rem=0, resp_dz=0, busy=0, and all internal registers cleared. An in-flight operation is dropped with no response. Release is synchronous to clk.
- Accept at edge E0. CALC steps occur on E1..E8 (WIDTH=8). SIGN registers results on E9. resp_valid is high from E9 until the response handshake.
- Latency is WIDTH+2 edges from accept to resp_valid.
- With resp_ready held high: handshake at E10, IDLE after E10, next accept at E11. Peak throughput is one division per WIDTH+3 cycles.
- req_ready is 0 in CALC, SIGN and RESP even if req_valid is high.
- Response stall: the FSM stays in RESP indefinitely; new requests wait.

## Test plan
- Reset, then req0 = 100 / 7 -> req_ready[0] pulses one cycle; resp_valid[0] rises exactly 10 cycles after accept; quo=0x0E, rem=0x02, dz=0.
- Sign matrix:
  - -100/7 -> quo=0xF2, rem=0xFE
  - 100/-7 -> quo=0xF2, rem=0x02
  - -100/-7 -> quo=0x0E, rem=0xFE
  - -128/-1 -> quo=0x80, rem=0x00
  - -128/1 -> quo=0x80, rem=0x00
- Divide by zero: 0x25/0 -> quo=0xFF, rem=0x25, dz=1. Also 0xA0/0 -> quo=0xFF, rem=0xA0, dz=1.
- Contention: both req_valid high from reset with 50/5 and 60/7 -> req0 served first (10 r 0), then req1 at the next IDLE (8 r 4). Repeat with both held -> grants alternate 0,1,0,1.
- Backpressure: hold resp_ready[0]=0 for 20 cycles -> resp_valid[0] and the result stay stable; req1 valid throughout gets no req_ready until resp_ready[0] is taken.
- Assert rst_n=0 at the CALC step-4 edge -> all outputs go to reset values immediately. After release, no stale response appears, and a fresh 9/2 returns 4 r 1.
